// File: rtl/jtag_ir_loader.sv
// rtl/jtag_ir_loader.sv - JTAG IR load initiator; optional post-reset TAP recovery via JTAG_IR_LOADER_TLR_EN
module jtag_ir_loader #(
    parameter int IR_WIDTH = 2,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IR_WIDTH-1:0] instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic                busy,
    output logic [IR_WIDTH-1:0] capture,
    output logic                capture_valid,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    localparam int PW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam int BW = (IR_WIDTH > 1) ? $clog2(IR_WIDTH) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(TCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(IR_WIDTH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL_DR,
        S_SEL_IR,
        S_CAPTURE,
        S_ENTER_SHIFT,
        S_SHIFT,
        S_UPDATE,
        S_RETURN,
        S_TLR_START,
        S_TLR
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic [IR_WIDTH-1:0] shadow_q, shadow_d;
    logic [IR_WIDTH-1:0] capture_q, capture_d;
    logic                cv_q, cv_d;
`ifdef JTAG_IR_LOADER_TLR_EN
    logic [2:0]          tlr_q, tlr_d;
`endif

    // Remaining instruction bits after the current one, and shadow with tdo entering at the MSB
    logic [IR_WIDTH-1:0] instr_sh;
    logic [IR_WIDTH-1:0] shadow_in;
    assign instr_sh  = instr_q >> 1;
    assign shadow_in = (shadow_q >> 1) | (IR_WIDTH'(tdo) << (IR_WIDTH - 1));

    // Next-state: one TAP step per tck period; tms/tdi only move at the start of a low phase
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        instr_d   = instr_q;
        shadow_d  = shadow_q;
        capture_d = capture_q;
        cv_d      = 1'b0;
`ifdef JTAG_IR_LOADER_TLR_EN
        tlr_d     = tlr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    state_d = S_SEL_DR;
                    instr_d = instr;
                    phase_d = '0;
                    tck_d   = 1'b0;
                    tms_d   = 1'b1;
                    tdi_d   = 1'b0;
                end
            end
`ifdef JTAG_IR_LOADER_TLR_EN
            S_TLR_START: begin
                state_d = S_TLR;
                tlr_d   = 3'd0;
                phase_d = '0;
                tck_d   = 1'b0;
                tms_d   = 1'b1;
            end
`endif
            default: begin
                if (phase_q != PH_LAST) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d = '0;
                    if (!tck_q) begin
                        tck_d = 1'b1;
                        if (state_q == S_SHIFT) begin
                            shadow_d = shadow_in;
                        end
                    end else begin
                        tck_d = 1'b0;
                        tdi_d = 1'b0;
                        tms_d = 1'b0;
                        case (state_q)
                            S_SEL_DR: begin
                                state_d = S_SEL_IR;
                                tms_d   = 1'b1;
                            end
                            S_SEL_IR:  state_d = S_CAPTURE;
                            S_CAPTURE: state_d = S_ENTER_SHIFT;
                            S_ENTER_SHIFT: begin
                                state_d = S_SHIFT;
                                bit_d   = '0;
                                tdi_d   = instr_q[0];
                                tms_d   = (BIT_LAST == '0);
                            end
                            S_SHIFT: begin
                                if (bit_q == BIT_LAST) begin
                                    state_d = S_UPDATE;
                                    tms_d   = 1'b1;
                                end else begin
                                    bit_d   = bit_q + 1'b1;
                                    instr_d = instr_sh;
                                    tdi_d   = instr_sh[0];
                                    tms_d   = (bit_d == BIT_LAST);
                                end
                            end
                            S_UPDATE: state_d = S_RETURN;
                            S_RETURN: begin
                                state_d   = S_IDLE;
                                capture_d = shadow_q;
                                cv_d      = 1'b1;
                            end
`ifdef JTAG_IR_LOADER_TLR_EN
                            // Five tms=1 periods reach Test-Logic-Reset, the sixth (tms=0) parks in Run-Test/Idle
                            S_TLR: begin
                                if (tlr_q == 3'd5) begin
                                    state_d = S_IDLE;
                                end else begin
                                    tlr_d = tlr_q + 3'd1;
                                    tms_d = (tlr_q < 3'd4);
                                end
                            end
`endif
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // State register; reset abandons any sequence and discards partial capture data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef JTAG_IR_LOADER_TLR_EN
            state_q <= S_TLR_START;
            tlr_q   <= 3'd0;
`else
            state_q <= S_IDLE;
`endif
            phase_q   <= '0;
            bit_q     <= '0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            instr_q   <= '0;
            shadow_q  <= '0;
            capture_q <= '0;
            cv_q      <= 1'b0;
        end else begin
`ifdef JTAG_IR_LOADER_TLR_EN
            tlr_q <= tlr_d;
`endif
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            instr_q   <= instr_d;
            shadow_q  <= shadow_d;
            capture_q <= capture_d;
            cv_q      <= cv_d;
        end
    end

    assign instr_ready   = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE) && (state_q != S_TLR_START);
    assign capture       = capture_q;
    assign capture_valid = cv_q;
    assign tck           = tck_q;
    assign tms           = tms_q;
    assign tdi           = tdi_q;

endmodule

// File: tb/tb_jtag_ir_loader.sv
// tb/tb_jtag_ir_loader.sv - self-checking bench for jtag_ir_loader with behavioural target TAPs
module tb_jtag_ir_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [1:0] instr_a, cap_a;
    logic       valid_a, ready_a, busy_a, cv_a, tck_a, tms_a, tdi_a;
    logic       tdo_a = 1'b0;
    logic [0:0] instr_b, cap_b;
    logic       valid_b, ready_b, busy_b, cv_b, tck_b, tms_b, tdi_b;
    logic       tdo_b = 1'b0;

    jtag_ir_loader #(.IR_WIDTH(2), .TCK_HALF(2)) u_a (
        .clk(clk), .rst_n(rst_a), .instr(instr_a), .instr_valid(valid_a),
        .instr_ready(ready_a), .busy(busy_a), .capture(cap_a), .capture_valid(cv_a),
        .tck(tck_a), .tms(tms_a), .tdi(tdi_a), .tdo(tdo_a));

    jtag_ir_loader #(.IR_WIDTH(1), .TCK_HALF(1)) u_b (
        .clk(clk), .rst_n(rst_b), .instr(instr_b), .instr_valid(valid_b),
        .instr_ready(ready_b), .busy(busy_b), .capture(cap_b), .capture_valid(cv_b),
        .tck(tck_b), .tms(tms_b), .tdi(tdi_b), .tdo(tdo_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // IEEE 1149.1 TAP next-state tables: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,6 PaDR,7 Ex2DR,
    // 8 UpDR,9 SelIR,10 CapIR,11 ShIR,12 Ex1IR,13 PaIR,14 Ex2IR,15 UpIR
    localparam int NX1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    localparam int NX0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};

`ifdef JTAG_IR_LOADER_TLR_EN
    int st_a = 4;
    int st_b = 4;
`else
    int st_a = 1;
    int st_b = 1;
`endif
    logic       trst_a = 1'b0, trst_b = 1'b0;
    logic [1:0] sr_a = '0, ir_a = '0, pat_a = 2'b01;
    logic [0:0] sr_b = '0, ir_b = '0, pat_b = 1'b1;
    bit         tq_tms_a[$], tq_tdi_a[$], tq_tms_b[$], tq_tdi_b[$];
    int         cv_cnt_a = 0, cv_cnt_b = 0;

    // Target TAP A: capture, shift and state advance on rising tck
    always @(posedge tck_a or posedge trst_a) begin
        if (trst_a) begin
            st_a <= 1;
        end else begin
            if (st_a == 10) sr_a <= pat_a;
            else if (st_a == 11) sr_a <= {tdi_a, sr_a[1]};
            st_a <= tms_a ? NX1[st_a] : NX0[st_a];
            tq_tms_a.push_back(tms_a);
            tq_tdi_a.push_back(tdi_a);
        end
    end

    // Target TAP A: tdo and IR update on falling tck
    always @(negedge tck_a) begin
        if (st_a == 11) tdo_a <= sr_a[0];
        if (st_a == 15) ir_a <= sr_a;
    end

    // Target TAP B, one-bit IR
    always @(posedge tck_b or posedge trst_b) begin
        if (trst_b) begin
            st_b <= 1;
        end else begin
            if (st_b == 10) sr_b <= pat_b;
            else if (st_b == 11) sr_b <= tdi_b;
            st_b <= tms_b ? NX1[st_b] : NX0[st_b];
            tq_tms_b.push_back(tms_b);
            tq_tdi_b.push_back(tdi_b);
        end
    end

    // Target TAP B falling-edge actions
    always @(negedge tck_b) begin
        if (st_b == 11) tdo_b <= sr_b[0];
        if (st_b == 15) ir_b <= sr_b;
    end

    // Completion pulse counters
    always @(posedge clk) begin
        if (cv_a) cv_cnt_a <= cv_cnt_a + 1;
        if (cv_b) cv_cnt_b <= cv_cnt_b + 1;
    end

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) if (i < 32) v[i] = q[i];
        return v;
    endfunction

    // Expected per-period tms: SelDR 1, SelIR 1, Capture 0, Exit-to-shift 0, shift 0..0 then 1, Update 1, Return 0
    function automatic logic [31:0] exp_tms(input int w);
        logic [31:0] v = '0;
        v[0]         = 1'b1;
        v[1]         = 1'b1;
        v[4 + w - 1] = 1'b1;
        v[4 + w]     = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] exp_tdi(input logic [31:0] ins);
        return ins << 4;
    endfunction

    task automatic run_a(input logic [1:0] ins, input logic [1:0] pat,
                         input logic [1:0] exp_cap, input logic [1:0] exp_ir, input string tag);
        int n;
        int cv0;
        pat_a = pat;
        tq_tms_a.delete();
        tq_tdi_a.delete();
        @(negedge clk);
        instr_a = ins;
        valid_a = 1'b1;
        n = 0;
        while (!ready_a && n < 300) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, ready_a, 1);
        cv0 = cv_cnt_a;
        @(negedge clk);
        valid_a = 1'b0;
        instr_a = 2'($urandom);
        chk({tag, "_busy_rise"}, {busy_a, ready_a}, 2'b10);
        n = 0;
        while (busy_a && n < 300) begin @(negedge clk); n++; end
        chk({tag, "_busy_clks"}, n, 32);
        chk({tag, "_cv"}, cv_a, 1);
        chk({tag, "_capture"}, cap_a, exp_cap);
        chk({tag, "_ready_done"}, ready_a, 1);
        chk({tag, "_target_ir"}, ir_a, exp_ir);
        chk({tag, "_nper"}, tq_tms_a.size(), 8);
        chk({tag, "_tms"}, pack(tq_tms_a), exp_tms(2));
        chk({tag, "_tdi"}, pack(tq_tdi_a), exp_tdi(32'(ins)));
        @(negedge clk);
        chk({tag, "_cv_one"}, {cv_a, 30'(cv_cnt_a - cv0)}, 31'd1);
    endtask

    task automatic run_b(input logic [0:0] ins, input logic [0:0] pat, input string tag);
        int n;
        pat_b = pat;
        tq_tms_b.delete();
        tq_tdi_b.delete();
        @(negedge clk);
        instr_b = ins;
        valid_b = 1'b1;
        n = 0;
        while (!ready_b && n < 300) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, ready_b, 1);
        @(negedge clk);
        valid_b = 1'b0;
        n = 0;
        while (busy_b && n < 300) begin @(negedge clk); n++; end
        chk({tag, "_busy_clks"}, n, 14);
        chk({tag, "_cv"}, cv_b, 1);
        chk({tag, "_capture"}, cap_b, pat);
        chk({tag, "_target_ir"}, ir_b, ins);
        chk({tag, "_nper"}, tq_tms_b.size(), 7);
        chk({tag, "_tms"}, pack(tq_tms_b), exp_tms(1));
        chk({tag, "_tdi"}, pack(tq_tdi_b), exp_tdi(32'(ins)));
    endtask

    typedef struct {
        logic [1:0] ins;
        logic [1:0] pat;
        logic [1:0] exp_cap;
        logic [1:0] exp_ir;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        int   n;
        int   cv0;
        tbl[0] = '{ins: 2'b11, pat: 2'b01, exp_cap: 2'b01, exp_ir: 2'd3};
        tbl[1] = '{ins: 2'b00, pat: 2'b01, exp_cap: 2'b01, exp_ir: 2'd0};
        tbl[2] = '{ins: 2'b10, pat: 2'b10, exp_cap: 2'b10, exp_ir: 2'd2};
        tbl[3] = '{ins: 2'b01, pat: 2'b11, exp_cap: 2'b11, exp_ir: 2'd1};

        rst_a = 1'b0; rst_b = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        instr_a = '0; instr_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {tck_a, tms_a, tdi_a, busy_a, cv_a, cap_a}, '0);
        chk("rst_outs_b", {tck_b, tms_b, tdi_b, busy_b, cv_b, cap_b}, '0);
`ifdef JTAG_IR_LOADER_TLR_EN
        chk("rst_ready_a", ready_a, 0);
        rst_a = 1'b1; rst_b = 1'b1;
        n = 0;
        while (!tms_a && n < 20) begin @(negedge clk); n++; end
        chk("tlr_busy", {busy_a, ready_a}, 2'b10);
        n = 0;
        while (!ready_a && n < 300) begin @(negedge clk); n++; end
        chk("tlr_clks", n, 24);
        chk("tlr_tms", pack(tq_tms_a), 32'b011111);
        chk("tlr_nper", tq_tms_a.size(), 6);
        chk("tlr_no_cv", cv_cnt_a, 0);
        chk("tlr_tap_rti", st_a, 1);
        n = 0;
        while (!ready_b && n < 300) begin @(negedge clk); n++; end
        chk("tlr_b_ready", ready_b, 1);
`else
        chk("rst_ready_a", ready_a, 1);
        chk("rst_ready_b", ready_b, 1);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
`endif

        for (int i = 0; i < 4; i++) begin
            run_a(tbl[i].ins, tbl[i].pat, tbl[i].exp_cap, tbl[i].exp_ir, $sformatf("vec%0d", i));
        end

        // Back-to-back: second request accepted on the completion clk of the first
        pat_a = 2'b01;
        @(negedge clk);
        instr_a = 2'b00;
        valid_a = 1'b1;
        @(negedge clk);
        chk("b2b_first_busy", busy_a, 1);
        instr_a = 2'b10;
        n = 0;
        while (busy_a && n < 300) begin @(negedge clk); n++; end
        chk("b2b_first_clks", n, 32);
        chk("b2b_first_ir", ir_a, 0);
        chk("b2b_first_cv", {cv_a, ready_a}, 2'b11);
        @(negedge clk);
        valid_a = 1'b0;
        chk("b2b_second_busy", busy_a, 1);
        n = 0;
        while (busy_a && n < 300) begin @(negedge clk); n++; end
        chk("b2b_second_clks", n, 32);
        chk("b2b_second_ir", ir_a, 2);
        chk("b2b_second_cap", {cv_a, cap_a}, 3'b101);

        // Request while busy is ignored and the in-flight load completes unchanged
        @(negedge clk);
        instr_a = 2'b10;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (9) @(negedge clk);
        instr_a = 2'b01;
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("busyreq_ready%0d", i), ready_a, 0);
        end
        valid_a = 1'b0;
        n = 14;
        while (busy_a && n < 300) begin @(negedge clk); n++; end
        chk("busyreq_clks", n, 32);
        chk("busyreq_ir", ir_a, 2);
        chk("busyreq_cv", cv_a, 1);
        @(negedge clk);
        chk("busyreq_idle", busy_a, 0);

        // Reset during the first SHIFT high phase
        pat_a = 2'b10;
        tq_tms_a.delete();
        tq_tdi_a.delete();
        @(negedge clk);
        instr_a = 2'b11;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        n = 0;
        while (tq_tms_a.size() < 5 && n < 300) begin @(negedge clk); n++; end
        chk("midrst_in_shift_high", {tck_a, busy_a}, 2'b11);
        cv0 = cv_cnt_a;
        #2;
        rst_a = 1'b0;
        #1;
        chk("midrst_outs", {tck_a, tms_a, tdi_a, busy_a, cv_a, cap_a}, '0);
`ifdef JTAG_IR_LOADER_TLR_EN
        chk("midrst_ready", ready_a, 0);
`else
        chk("midrst_ready", ready_a, 1);
`endif
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
`ifndef JTAG_IR_LOADER_TLR_EN
        trst_a = 1'b1;
        #1;
        trst_a = 1'b0;
`endif
        n = 0;
        while (!ready_a && n < 300) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        chk("midrst_no_cv", cv_cnt_a - cv0, 0);
        chk("midrst_cap_zero", cap_a, 0);

        // Randomized loads checked against the sequence model
        for (int i = 0; i < 16; i++) begin
            logic [1:0] ri, rp;
            ri = 2'($urandom_range(0, 3));
            rp = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_a(ri, rp, rp, ri, $sformatf("rnd%0d", i));
        end

        // Minimum configuration: IR_WIDTH=1, TCK_HALF=1
        run_b(1'b1, 1'b1, "min_a");
        run_b(1'b1, 1'b0, "min_b");
        run_b(1'b0, 1'b1, "min_c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
